mem_stage_hs: RTL and testbench
===============================

# mem_stage_hs

Memory-access pipeline stage for the five-stage MIPS core, between EXE and WB, for a data SRAM with a variable-latency request/response handshake. It tracks one outstanding data transaction, holds the instruction until `data_ok`, and sign/zero-extends sub-word loads. It buffers returned data when WB back-pressures and discards responses that belong to flushed instructions. It also drives forwarding and load-use stall signals to ID.

## Interface
- `DATA_W`, 32: datapath / SRAM data width (multiple of 32).
- `REG_W`, 5: register-index width.
- `EXC_W`, 5: exception-code width.
- Clock and reset: `reset` is synchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `es_to_ms_valid`  in  1  EXE holds a valid instruction
- `ms_allowin`  out  1  MEM accepts from EXE this cycle
- `es_req_issued`  in  1  EXE's SRAM request was address-accepted (load or store)
- `es_pc`, `es_alu_result`  in  32 / DATA_W  pc, address or ALU result
- `es_dest`  in  REG_W; `es_gr_we`  in  1
- `es_ld_op`  in  3  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw
- `es_ex`  in  1; `es_excode`  in  EXC_W
- `data_sram_data_ok`  in  1; `data_sram_rdata`  in  DATA_W
- `flush`  in  1  exception/eret flush from WB
- `ws_allowin`  in  1; `ms_to_ws_valid`  out  1
- `ms_pc`, `ms_result`, `ms_dest`, `ms_gr_we`, `ms_ex`, `ms_excode`  out  WB payload
- `ms_fwd_dest`  out  REG_W  dest if valid and `gr_we`, else 0
- `ms_fwd_result`  out  DATA_W; `ms_fwd_stall`  out  1  load in MEM, data not yet available

## Operation
- Payload registers load on `es_to_ms_valid && ms_allowin`. `ms_valid` loads `es_to_ms_valid` when `ms_allowin`. `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- FSM per resident instruction:
  - IDLE: no wait.
  - WAIT: `es_req_issued` was set at entry and `es_ex` was 0.
  - DONE: data captured in `rdata_buf`.
- WAIT → DONE when `data_ok` arrives and `!ws_allowin`.
- WAIT → IDLE, or the next instruction's state, when `data_ok` arrives and `ws_allowin`.
- DONE → next state on handoff.
- `ms_ready_go`: 1 in IDLE and DONE; in WAIT equals `data_ok && !discard`.
- Load result, with `off = alu_result[1:0]`, from live `rdata` in WAIT or from `rdata_buf` in DONE:
  - lb/lbu: byte at `off`.
  - lh/lhu: halfword at `off[1]`.
  - lw: whole word.
  - Sign- or zero-extend to DATA_W.
- Non-loads, including stores: `ms_result = alu_result`. A store in WAIT still waits for its write `data_ok`.
- `es_ex=1`: no wait; forwards the exception to WB unchanged.
- Flush:
  - Same cycle: `ms_valid<=0`, state<=IDLE.
  - If state is WAIT and `data_ok` is not asserted this cycle, set `discard<=1`.
  - The next `data_ok` while `discard=1` clears `discard` and is otherwise ignored.
  - Responses are in order with at most one outstanding, so a 1-bit `discard` suffices.
- Simultaneous `data_ok` with `discard=1` and a new instruction in WAIT: the response goes to `discard`; the instruction keeps waiting.
- `ms_fwd_stall = ms_valid && ld_op!=0 && !ms_ready_go`.

## Timing
- Reset values:
  - `ms_valid`=0, state IDLE, `discard`=0, `rdata_buf`=0.
  - All outputs 0; `ms_allowin`=1.
- Minimum latency 1 cycle: `data_ok` may arrive in the first MEM cycle; the result is combinational to WB in that cycle.
- Hold: the payload and `ms_to_ws_valid` are stable while `!ws_allowin`.
- `flush` overrides entry in the same cycle; nothing is accepted on a flush cycle.

## Structure
- Shared header `mycpu.h`: `LD_NONE`…`LD_LW` codes and the EXC_W excode constants.
- Optional sub-module `load_align`: a combinational byte/halfword select and extend, parametrised by DATA_W.
- Everything else stays in `mem_stage_hs`.

## Test plan
- lw, `addr=0x1004`, `data_ok` 3 cycles after entry, rdata=0x80FF_1234 → stall 2 cycles, `ms_result=0x80FF1234`, handoff in cycle 3.
- lb off=3, rdata=0x80FF_1234 → 0xFFFF_FF80. lbu off=2 → 0x0000_00FF. lh off=2 → 0xFFFF_80FF. lhu off=0 → 0x0000_1234.
- `data_ok` with `ws_allowin=0` for 2 cycles → state DONE, result held from `rdata_buf`, released when `ws_allowin` rises.
- Flush during WAIT, then a new lw enters; first `data_ok` rdata=0xDEAD → discarded; second rdata=0xBEEF → `ms_result=0xBEEF`.
- `es_ex=1`, excode 4 (AdEL) → no wait, `ms_ex=1`, `ms_excode=4` to WB next cycle.
- Reset asserted mid-WAIT → next cycle all outputs 0, `discard=0`, `ms_allowin=1`.

Source files
------------

// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the MEM stage: load-op codes, exception codes,
// the per-instruction wait state and a small load helper.
package mem_stage_hs_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ms_state_e;

    function automatic logic ld_is_signed(input logic [2:0] op);
        return (op == LD_LB) || (op == LD_LH);
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// EXE -> MEM instruction bus with its allowin back-pressure.
interface mem_stage_hs_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int EXC_W  = 5
);
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic              es_req_issued;
    logic [31:0]       es_pc;
    logic [DATA_W-1:0] es_alu_result;
    logic [REG_W-1:0]  es_dest;
    logic              es_gr_we;
    logic [2:0]        es_ld_op;
    logic              es_ex;
    logic [EXC_W-1:0]  es_excode;

    modport master (
        output es_to_ms_valid, es_req_issued, es_pc, es_alu_result,
               es_dest, es_gr_we, es_ld_op, es_ex, es_excode,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_req_issued, es_pc, es_alu_result,
               es_dest, es_gr_we, es_ld_op, es_ex, es_excode,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage_hs_load_align.sv
// Byte/halfword select from a loaded word followed by sign or zero extension.
module mem_stage_hs_load_align
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ld_op_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sext_s;

    // Lane select and extension.
    always_comb begin
        byte_s = word_i[{off_i, 3'b000} +: 8];
        half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
        sext_s = 1'b0;
        data_o = word_i;
        case (ld_op_i)
            LD_LB, LD_LBU: begin
                sext_s = ld_is_signed(ld_op_i) & byte_s[7];
                data_o = {{(DATA_W-8){sext_s}}, byte_s};
            end
            LD_LH, LD_LHU: begin
                sext_s = ld_is_signed(ld_op_i) & half_s[15];
                data_o = {{(DATA_W-16){sext_s}}, half_s};
            end
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds one instruction until its SRAM response, buffers
// data under WB back-pressure and drops responses of flushed instructions.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int EXC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_hs_if.slave     es_bus,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_pc,
    output logic [DATA_W-1:0] ms_result,
    output logic [REG_W-1:0]  ms_dest,
    output logic              ms_gr_we,
    output logic              ms_ex,
    output logic [EXC_W-1:0]  ms_excode,
    output logic [REG_W-1:0]  ms_fwd_dest,
    output logic [DATA_W-1:0] ms_fwd_result,
    output logic              ms_fwd_stall
);
    ms_state_e         state_q, state_d;
    logic              valid_q, valid_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
    logic [31:0]       pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_W-1:0]  dest_q;
    logic              gr_we_q;
    logic [2:0]        ld_op_q;
    logic              ex_q;
    logic [EXC_W-1:0]  excode_q;

    logic              ready_go_s;
    logic              allowin_s;
    logic              accept_s;
    logic [DATA_W-1:0] load_word_s;
    logic [DATA_W-1:0] load_data_s;

    // Readiness: only a WAIT instruction depends on a live, non-discarded response.
    always_comb begin
        ready_go_s = 1'b1;
        case (state_q)
            ST_WAIT: ready_go_s = data_sram_data_ok & ~discard_q;
            default: ready_go_s = 1'b1;
        endcase
    end

    assign allowin_s         = ~valid_q | (ready_go_s & ws_allowin);
    assign accept_s          = es_bus.es_to_ms_valid & allowin_s & ~flush;
    assign es_bus.ms_allowin = allowin_s;

    // Next state, valid, discard and response buffer.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rdata_buf_d = rdata_buf_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else if (allowin_s) begin
            valid_d = es_bus.es_to_ms_valid;
            state_d = (accept_s & es_bus.es_req_issued & ~es_bus.es_ex) ? ST_WAIT : ST_IDLE;
        end else if ((state_q == ST_WAIT) && ready_go_s) begin
            state_d     = ST_DONE;
            rdata_buf_d = data_sram_rdata;
        end else begin
            state_d = state_q;
        end
        // A flushed WAIT leaves its response in flight unless it lands now.
        if (flush && (state_q == ST_WAIT)) begin
            discard_d = discard_q | ~data_sram_data_ok;
        end else begin
            discard_d = discard_q & ~data_sram_data_ok;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            discard_q   <= 1'b0;
            rdata_buf_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            discard_q   <= discard_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Payload registers, loaded only on an accepted handoff from EXE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= 32'd0;
            alu_q    <= {DATA_W{1'b0}};
            dest_q   <= {REG_W{1'b0}};
            gr_we_q  <= 1'b0;
            ld_op_q  <= LD_NONE;
            ex_q     <= 1'b0;
            excode_q <= {EXC_W{1'b0}};
        end else if (accept_s) begin
            pc_q     <= es_bus.es_pc;
            alu_q    <= es_bus.es_alu_result;
            dest_q   <= es_bus.es_dest;
            gr_we_q  <= es_bus.es_gr_we;
            ld_op_q  <= es_bus.es_ld_op;
            ex_q     <= es_bus.es_ex;
            excode_q <= es_bus.es_excode;
        end else begin
            pc_q <= pc_q;
        end
    end

    assign load_word_s = (state_q == ST_DONE) ? rdata_buf_q : data_sram_rdata;

    mem_stage_hs_load_align #(.DATA_W(DATA_W)) u_align (
        .ld_op_i (ld_op_q),
        .off_i   (alu_q[1:0]),
        .word_i  (load_word_s),
        .data_o  (load_data_s)
    );

    assign ms_to_ws_valid = valid_q & ready_go_s;
    assign ms_pc          = pc_q;
    assign ms_result      = ((ld_op_q != LD_NONE) && !ex_q) ? load_data_s : alu_q;
    assign ms_dest        = dest_q;
    assign ms_gr_we       = gr_we_q;
    assign ms_ex          = ex_q;
    assign ms_excode      = excode_q;
    assign ms_fwd_dest    = (valid_q & gr_we_q) ? dest_q : {REG_W{1'b0}};
    assign ms_fwd_result  = ms_result;
    assign ms_fwd_stall   = valid_q & (ld_op_q != LD_NONE) & ~ready_go_s;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: load-extension table, directed
// handshake corner cases and a randomized run against a queue-based model.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ok, flush, ws_allowin;
    logic [31:0] rdata;
    logic        ms_to_ws_valid, ms_gr_we, ms_ex, ms_fwd_stall;
    logic [31:0] ms_pc, ms_result, ms_fwd_result;
    logic [4:0]  ms_dest, ms_excode, ms_fwd_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_hs_if #(.DATA_W(32), .REG_W(5), .EXC_W(5)) es_bus ();

    mem_stage_hs #(.DATA_W(32), .REG_W(5), .EXC_W(5)) dut (
        .clk(clk), .reset(reset), .es_bus(es_bus),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .flush(flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_result(ms_result),
        .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result), .ms_fwd_stall(ms_fwd_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic es_idle();
        es_bus.es_to_ms_valid = 1'b0;
        es_bus.es_req_issued  = 1'b0;
        es_bus.es_pc          = 32'd0;
        es_bus.es_alu_result  = 32'd0;
        es_bus.es_dest        = 5'd0;
        es_bus.es_gr_we       = 1'b0;
        es_bus.es_ld_op       = LD_NONE;
        es_bus.es_ex          = 1'b0;
        es_bus.es_excode      = 5'd0;
    endtask

    task automatic enter(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [4:0] dest, input logic req, input logic ex,
                         input logic [4:0] exc);
        es_bus.es_to_ms_valid = 1'b1;
        es_bus.es_req_issued  = req;
        es_bus.es_pc          = pc;
        es_bus.es_alu_result  = alu;
        es_bus.es_dest        = dest;
        es_bus.es_gr_we       = (op != LD_NONE);
        es_bus.es_ld_op       = op;
        es_bus.es_ex          = ex;
        es_bus.es_excode      = exc;
    endtask

    // Load value as software sees it: shift the lane down, mask, extend.
    function automatic logic [31:0] ext(input logic [2:0] op, input int unsigned off,
                                        input logic [31:0] src);
        logic [31:0] b, h;
        b = (src >> (8 * off)) & 32'hFF;
        h = (src >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            LD_LB:   return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            LD_LBU:  return b;
            LD_LH:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            LD_LHU:  return h;
            default: return src;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          stale;
        int          rdy;
        logic [31:0] d;
    } resp_t;

    vec_t  vt[9];
    resp_t q[$];
    resp_t e;

    bit          r_valid, r_wait, r_we, r_ex;
    logic [31:0] r_pc, r_alu, r_data, exp_res;
    logic [4:0]  r_dest, r_exc;
    logic [2:0]  r_ld;
    bit          live_now, stale_now, m_ready, m_allowin, m_to_ws, delivered;
    bit          v, ex, req;
    logic [2:0]  op;

    initial begin
        vt[0] = '{LD_LB,   32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80};
        vt[1] = '{LD_LBU,  32'h0000_0102, 32'h80FF_1234, 32'h0000_00FF};
        vt[2] = '{LD_LH,   32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF};
        vt[3] = '{LD_LHU,  32'h0000_0100, 32'h80FF_1234, 32'h0000_1234};
        vt[4] = '{LD_LB,   32'h0000_0100, 32'h80FF_1234, 32'h0000_0034};
        vt[5] = '{LD_LB,   32'h0000_0101, 32'h0000_A500, 32'hFFFF_FFA5};
        vt[6] = '{LD_LH,   32'h0000_0100, 32'h0000_8001, 32'hFFFF_8001};
        vt[7] = '{LD_LW,   32'h0000_0104, 32'h7654_3210, 32'h7654_3210};
        vt[8] = '{LD_NONE, 32'h0000_2008, 32'hAAAA_AAAA, 32'h0000_2008};

        es_idle();
        data_ok = 1'b0; rdata = 32'd0; flush = 1'b0; ws_allowin = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #3;
        chk("rst_allowin", {31'd0, es_bus.ms_allowin}, 32'd1);
        chk("rst_to_ws",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_pc",      ms_pc, 32'd0);
        chk("rst_result",  ms_result, 32'd0);
        chk("rst_stall",   {31'd0, ms_fwd_stall}, 32'd0);
        chk("rst_fwd_dest",{27'd0, ms_fwd_dest}, 32'd0);

        // lw with data_ok three cycles after entry.
        enter(LD_LW, 32'h0000_0400, 32'h0000_1004, 5'd7, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); #3;
        chk("lw_c1_stall",   {31'd0, ms_fwd_stall}, 32'd1);
        chk("lw_c1_to_ws",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("lw_c1_allowin", {31'd0, es_bus.ms_allowin}, 32'd0);
        chk("lw_c1_fwd_dest",{27'd0, ms_fwd_dest}, 32'd7);
        step(); #3;
        chk("lw_c2_stall",   {31'd0, ms_fwd_stall}, 32'd1);
        step(); data_ok = 1'b1; rdata = 32'h80FF_1234; #3;
        chk("lw_c3_to_ws",   {31'd0, ms_to_ws_valid}, 32'd1);
        chk("lw_c3_result",  ms_result, 32'h80FF_1234);
        chk("lw_c3_stall",   {31'd0, ms_fwd_stall}, 32'd0);
        step(); data_ok = 1'b0; #3;
        chk("lw_after_to_ws",{31'd0, ms_to_ws_valid}, 32'd0);

        // Extension table, response in the first MEM cycle.
        for (int i = 0; i < 9; i++) begin
            enter(vt[i].op, 32'h0000_0500 + 32'(i * 4), vt[i].addr, 5'(i + 1), 1'b1, 1'b0, 5'd0);
            step(); es_idle(); data_ok = 1'b1; rdata = vt[i].rd; #3;
            chk($sformatf("tbl%0d_to_ws", i), {31'd0, ms_to_ws_valid}, 32'd1);
            chk($sformatf("tbl%0d_result", i), ms_result, vt[i].exp);
            chk($sformatf("tbl%0d_fwd", i), ms_fwd_result, vt[i].exp);
            step(); data_ok = 1'b0;
        end

        // Back-pressure: response buffered while WB stalls.
        enter(LD_LH, 32'h0000_0600, 32'h0000_0102, 5'd9, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); data_ok = 1'b1; rdata = 32'h80FF_1234; ws_allowin = 1'b0; #3;
        chk("bp_c1_to_ws",   {31'd0, ms_to_ws_valid}, 32'd1);
        chk("bp_c1_allowin", {31'd0, es_bus.ms_allowin}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(); data_ok = 1'b0; rdata = 32'h1111_1111; #3;
            chk($sformatf("bp_hold%0d_to_ws", k), {31'd0, ms_to_ws_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_result", k), ms_result, 32'hFFFF_80FF);
            chk($sformatf("bp_hold%0d_allowin", k), {31'd0, es_bus.ms_allowin}, 32'd0);
        end
        ws_allowin = 1'b1; #1;
        chk("bp_rel_allowin", {31'd0, es_bus.ms_allowin}, 32'd1);
        chk("bp_rel_result",  ms_result, 32'hFFFF_80FF);
        step(); #3;
        chk("bp_after_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);

        // Flush during WAIT, stale response discarded, next one delivered.
        enter(LD_LW, 32'h0000_0700, 32'h0000_3000, 5'd3, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); flush = 1'b1; #3;
        chk("fl_wait_stall", {31'd0, ms_fwd_stall}, 32'd1);
        step(); flush = 1'b0; #3;
        chk("fl_to_ws",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("fl_allowin", {31'd0, es_bus.ms_allowin}, 32'd1);
        enter(LD_LW, 32'h0000_0704, 32'h0000_3004, 5'd4, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); data_ok = 1'b1; rdata = 32'h0000_DEAD; #3;
        chk("fl_stale_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("fl_stale_stall", {31'd0, ms_fwd_stall}, 32'd1);
        step(); data_ok = 1'b0; #3;
        chk("fl_gap_stall",   {31'd0, ms_fwd_stall}, 32'd1);
        step(); data_ok = 1'b1; rdata = 32'h0000_BEEF; #3;
        chk("fl_live_to_ws",  {31'd0, ms_to_ws_valid}, 32'd1);
        chk("fl_live_result", ms_result, 32'h0000_BEEF);
        chk("fl_live_dest",   {27'd0, ms_dest}, 32'd4);
        step(); data_ok = 1'b0;

        // Exception passes straight through.
        enter(LD_LW, 32'hBFC0_0100, 32'h0000_1001, 5'd2, 1'b0, 1'b1, EXC_ADEL);
        step(); es_idle(); #3;
        chk("ex_to_ws",  {31'd0, ms_to_ws_valid}, 32'd1);
        chk("ex_flag",   {31'd0, ms_ex}, 32'd1);
        chk("ex_code",   {27'd0, ms_excode}, 32'd4);
        chk("ex_pc",     ms_pc, 32'hBFC0_0100);
        chk("ex_stall",  {31'd0, ms_fwd_stall}, 32'd0);
        step();

        // Reset in the middle of a WAIT.
        enter(LD_LW, 32'h0000_0800, 32'h0000_0040, 5'd5, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); #3;
        chk("rw_stall", {31'd0, ms_fwd_stall}, 32'd1);
        reset = 1'b1;
        step(); reset = 1'b0; #3;
        chk("rw_allowin", {31'd0, es_bus.ms_allowin}, 32'd1);
        chk("rw_to_ws",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rw_pc",      ms_pc, 32'd0);
        chk("rw_result",  ms_result, 32'd0);
        chk("rw_dest",    {27'd0, ms_dest}, 32'd0);
        chk("rw_stall0",  {31'd0, ms_fwd_stall}, 32'd0);
        enter(LD_LW, 32'h0000_0804, 32'h0000_0044, 5'd6, 1'b1, 1'b0, 5'd0);
        step(); es_idle(); data_ok = 1'b1; rdata = 32'h0000_0055; #3;
        chk("rw_next_to_ws",  {31'd0, ms_to_ws_valid}, 32'd1);
        chk("rw_next_result", ms_result, 32'h0000_0055);
        step(); data_ok = 1'b0;

        // Randomized run against the response-queue model.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        r_valid = 1'b0; r_wait = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush      = (q.size() <= 1) && ($urandom_range(0, 15) == 0);
            ws_allowin = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 1) == 1);
            op  = 3'($urandom_range(0, 5));
            ex  = ($urandom_range(0, 9) == 0);
            req = v && !ex && ((op != LD_NONE) || ($urandom_range(0, 3) == 0));
            if (v) enter(op, $urandom, $urandom, 5'($urandom_range(0, 31)), req, ex, 5'($urandom_range(0, 31)));
            else   es_idle();
            es_bus.es_gr_we = v && ($urandom_range(0, 1) == 1);
            data_ok = (q.size() > 0) && (cyc >= q[0].rdy);
            rdata   = data_ok ? q[0].d : $urandom;
            #3;
            live_now  = 1'b0;
            stale_now = 1'b0;
            if (data_ok) begin
                live_now  = !q[0].stale;
                stale_now = q[0].stale;
            end
            m_ready   = !r_valid || !r_wait || live_now;
            m_allowin = !r_valid || (m_ready && ws_allowin);
            m_to_ws   = r_valid && m_ready;
            chk("rnd_allowin", {31'd0, es_bus.ms_allowin}, {31'd0, m_allowin});
            chk("rnd_to_ws",   {31'd0, ms_to_ws_valid}, {31'd0, m_to_ws});
            chk("rnd_stall",   {31'd0, ms_fwd_stall}, {31'd0, r_valid && (r_ld != LD_NONE) && !m_ready});
            chk("rnd_fwd_dest",{27'd0, ms_fwd_dest}, (r_valid && r_we) ? {27'd0, r_dest} : 32'd0);
            if (m_to_ws) begin
                exp_res = ((r_ld != LD_NONE) && !r_ex) ? ext(r_ld, r_alu % 4, r_wait ? rdata : r_data) : r_alu;
                chk("rnd_pc",     ms_pc, r_pc);
                chk("rnd_result", ms_result, exp_res);
                chk("rnd_dest",   {27'd0, ms_dest}, {27'd0, r_dest});
                chk("rnd_gr_we",  {31'd0, ms_gr_we}, {31'd0, r_we});
                chk("rnd_ex",     {31'd0, ms_ex}, {31'd0, r_ex});
                chk("rnd_excode", {27'd0, ms_excode}, {27'd0, r_exc});
            end
            delivered = data_ok && !stale_now;
            if (data_ok) void'(q.pop_front());
            if (flush) begin
                if (r_valid && r_wait && !delivered && (q.size() > 0)) begin
                    e = q[q.size() - 1];
                    e.stale = 1'b1;
                    q[q.size() - 1] = e;
                end
                r_valid = 1'b0;
            end else if (m_allowin) begin
                r_valid = v;
                if (v) begin
                    r_pc = es_bus.es_pc; r_alu = es_bus.es_alu_result; r_dest = es_bus.es_dest;
                    r_we = es_bus.es_gr_we; r_ld = op; r_ex = ex; r_exc = es_bus.es_excode;
                    r_wait = req;
                    if (req) begin
                        e.stale = 1'b0;
                        e.rdy   = cyc + 1 + int'($urandom_range(0, 3));
                        e.d     = $urandom;
                        q.push_back(e);
                    end
                end
            end else if (delivered && r_wait) begin
                r_wait = 1'b0;
                r_data = rdata;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
